// File: rtl/mod_down_counter_if.sv
// Request/response bundle for mod_down_counter: raw button levels and modulus in,
// registered count and status flags out.
interface mod_down_counter_if #(
    parameter int WIDTH = 3
);
    logic             step;
    logic             load;
    logic [WIDTH-1:0] mod_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             toggle;
    logic             mod_err;

    modport master (
        output step, load, mod_in,
        input  count, tc, toggle, mod_err
    );

    modport slave (
        input  step, load, mod_in,
        output count, tc, toggle, mod_err
    );
endinterface

// File: rtl/mod_down_counter.sv
// Loadable modulo down-counter driven by raw asynchronous step/load levels.
// Each level is synchronized, edge-detected and acted on as a one-cycle pulse.
module mod_down_counter #(
    parameter int WIDTH       = 3,
    parameter int DEFAULT_MOD = 7
) (
    input  logic               clk,
    input  logic               reset,
    mod_down_counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_MOD   = WIDTH'(2);
    localparam logic [WIDTH-1:0] RESET_MOD = WIDTH'(DEFAULT_MOD);
    localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(DEFAULT_MOD - 1);

    logic [2:0]       step_sync;
    logic [2:0]       load_sync;
    logic             step_p;
    logic             load_p;
    logic [WIDTH-1:0] mod_r;
    logic [WIDTH-1:0] count_r;
    logic             tc_r;
    logic             toggle_r;
    logic             mod_err_r;
    logic             load_legal;

    // Bits [1:0] are the synchronizer pair, bit [2] is the edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_sync <= '0;
            load_sync <= '0;
        end else begin
            step_sync <= {step_sync[1:0], bus.step};
            load_sync <= {load_sync[1:0], bus.load};
        end
    end

    always_comb begin
        step_p     = step_sync[1] & ~step_sync[2];
        load_p     = load_sync[1] & ~load_sync[2];
        load_legal = (bus.mod_in >= MIN_MOD);
    end

    // Load takes priority over step; a load never counts as a wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mod_r     <= RESET_MOD;
            count_r   <= RESET_CNT;
            tc_r      <= 1'b0;
            toggle_r  <= 1'b0;
            mod_err_r <= 1'b0;
        end else begin
            tc_r <= 1'b0;
            if (load_p) begin
                if (load_legal) begin
                    mod_r     <= bus.mod_in;
                    count_r   <= bus.mod_in - ONE;
                    mod_err_r <= 1'b0;
                end else begin
                    mod_err_r <= 1'b1;
                end
            end else if (step_p) begin
                if (count_r == '0) begin
                    count_r  <= mod_r - ONE;
                    tc_r     <= 1'b1;
                    toggle_r <= ~toggle_r;
                end else begin
                    count_r <= count_r - ONE;
                end
            end
        end
    end

    assign bus.count   = count_r;
    assign bus.tc      = tc_r;
    assign bus.toggle  = toggle_r;
    assign bus.mod_err = mod_err_r;
endmodule

// File: tb/tb_mod_down_counter.sv
// Directed bench for mod_down_counter: synchronizer latency, wraps, loads,
// illegal moduli, load/step collision and asynchronous reset.
module tb_mod_down_counter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mod_down_counter_if #(.WIDTH(3)) bus ();

    mod_down_counter #(.WIDTH(3), .DEFAULT_MOD(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise levels just before edge N; the action is visible after edge N+2.
    task automatic act(input logic s, input logic l);
        @(negedge clk);
        bus.step = s;
        bus.load = l;
        repeat (3) tick();
    endtask

    task automatic release_in();
        @(negedge clk);
        bus.step = 1'b0;
        bus.load = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_step(input int exp_cnt, input int exp_tc);
        act(1'b1, 1'b0);
        check_eq("step_count", bus.count, exp_cnt);
        check_eq("step_tc", bus.tc, exp_tc);
        release_in();
        check_eq("tc_cleared", bus.tc, 0);
    endtask

    task automatic do_load(input int m, input int exp_cnt, input int exp_err);
        bus.mod_in = 3'(m);
        act(1'b0, 1'b1);
        check_eq("load_count", bus.count, exp_cnt);
        check_eq("load_err", bus.mod_err, exp_err);
        check_eq("load_tc", bus.tc, 0);
        release_in();
    endtask

    initial begin
        int cnt;
        int wrap;
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.step   = 1'b0;
        bus.load   = 1'b0;
        bus.mod_in = 3'd0;
        repeat (3) tick();
        check_eq("rst_count", bus.count, 6);
        check_eq("rst_tc", bus.tc, 0);
        check_eq("rst_toggle", bus.toggle, 0);
        check_eq("rst_err", bus.mod_err, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();

        // Seven presses at the default modulus: one wrap on the last.
        for (int i = 1; i <= 7; i++)
            do_step((i == 7) ? 6 : 6 - i, (i == 7) ? 1 : 0);
        check_eq("wrap_toggle", bus.toggle, 1);

        // Latency and single pulse for a long hold.
        @(negedge clk);
        bus.step = 1'b1;
        tick();
        check_eq("lat_edgeN", bus.count, 6);
        tick();
        check_eq("lat_edgeN1", bus.count, 6);
        tick();
        check_eq("lat_edgeN2", bus.count, 5);
        repeat (20) tick();
        check_eq("hold_once", bus.count, 5);
        release_in();

        // Load a smaller modulus mid-count.
        do_step(4, 0);
        do_load(3, 2, 0);
        do_step(1, 0);
        do_step(0, 0);
        do_step(2, 1);
        check_eq("mod3_toggle", bus.toggle, 0);

        // Illegal load leaves modulus 3 in force.
        do_load(1, 2, 1);
        do_step(1, 0);
        do_step(0, 0);
        do_step(2, 1);
        check_eq("err_sticky", bus.mod_err, 1);
        check_eq("illegal_toggle", bus.toggle, 1);
        do_load(5, 4, 0);
        do_load(0, 4, 1);
        do_load(7, 6, 0);

        // Simultaneous step and load: load wins.
        bus.mod_in = 3'd4;
        act(1'b1, 1'b1);
        check_eq("both_count", bus.count, 3);
        check_eq("both_tc", bus.tc, 0);
        check_eq("both_toggle", bus.toggle, 1);
        release_in();

        // Load while at zero is not a wrap; modulus 2 wraps every other step.
        do_step(2, 0);
        do_step(1, 0);
        do_step(0, 0);
        do_load(2, 1, 0);
        check_eq("load0_toggle", bus.toggle, 1);
        do_step(0, 0);
        do_step(1, 1);
        check_eq("mod2_toggle_a", bus.toggle, 0);
        do_step(0, 0);
        do_step(1, 1);
        check_eq("mod2_toggle_b", bus.toggle, 1);

        // Count past two wraps with an error pending, then reset asynchronously.
        do_load(7, 6, 0);
        do_load(0, 6, 1);
        cnt = 6;
        for (int i = 0; i < 15; i++) begin
            wrap = (cnt == 0) ? 1 : 0;
            cnt  = (cnt == 0) ? 6 : cnt - 1;
            do_step(cnt, wrap);
        end
        check_eq("pre_rst_count", bus.count, 5);
        check_eq("pre_rst_toggle", bus.toggle, 1);
        @(posedge clk);
        #3;
        reset    = 1'b0;
        bus.step = 1'b1;
        #1;
        check_eq("async_count", bus.count, 6);
        check_eq("async_toggle", bus.toggle, 0);
        check_eq("async_tc", bus.tc, 0);
        check_eq("async_err", bus.mod_err, 0);

        // Step held high across release yields exactly one decrement.
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_eq("rel_edge1", bus.count, 6);
        tick();
        check_eq("rel_edge2", bus.count, 6);
        tick();
        check_eq("rel_edge3", bus.count, 5);
        repeat (10) tick();
        check_eq("rel_once", bus.count, 5);
        release_in();
        do_step(4, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
